// File: rtl/smps_pkg.sv
// Shared types and constants for the multiphase digital PWM.
package smps_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dpwm_state_t;

  localparam int DPWM_CNT_W = 11;
  localparam int DPWM_DT_W  = 5;

  // Start value of phase k's counter on RUN entry; spreads the phases evenly
  // over one switching period, phase 0 starting at 0.
  function automatic int phase_offset(input int k, input int period, input int n_ph);
    return (period - (k * (period / n_ph))) % period;
  endfunction

endpackage

// File: rtl/dpwm_multiphase_if.sv
// Duty-source / gate-drive bundle of the multiphase DPWM.
// Optional over-current trip signals exist only when DPWM_OC_TRIP_EN is defined.
interface dpwm_multiphase_if #(
  parameter int CNT_W = 11,
  parameter int DT_W  = 5,
  parameter int N_PH  = 2
) ();

  logic              i_enable;
  logic [CNT_W-1:0]  i_ton;
  logic [DT_W-1:0]   i_dt1;
  logic [DT_W-1:0]   i_dt2;
  logic [N_PH-1:0]   o_c1;
  logic [N_PH-1:0]   o_c2;
  logic              o_sync;
  logic              o_clamped;
  logic              o_running;
`ifdef DPWM_OC_TRIP_EN
  logic              i_oc_trip;
  logic              o_trip;

  modport master (output i_enable, i_ton, i_dt1, i_dt2, i_oc_trip,
                  input  o_c1, o_c2, o_sync, o_clamped, o_running, o_trip);
  modport slave  (input  i_enable, i_ton, i_dt1, i_dt2, i_oc_trip,
                  output o_c1, o_c2, o_sync, o_clamped, o_running, o_trip);
`else
  modport master (output i_enable, i_ton, i_dt1, i_dt2,
                  input  o_c1, o_c2, o_sync, o_clamped, o_running);
  modport slave  (input  i_enable, i_ton, i_dt1, i_dt2,
                  output o_c1, o_c2, o_sync, o_clamped, o_running);
`endif

endinterface

// File: rtl/dpwm_phase.sv
// One DPWM channel: period counter, armed bit, shadowed duty/dead-time,
// duty clamp and registered complementary gate pair.
// DPWM_OC_TRIP_EN adds a per-phase over-current trip that blanks c1.
module dpwm_phase
  import smps_pkg::*;
#(
  parameter int CNT_W  = DPWM_CNT_W,
  parameter int DT_W   = DPWM_DT_W,
  parameter int PERIOD = 1000,
  parameter int N_PH   = 2,
  parameter int PH_IDX = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             start,
  input  logic [CNT_W-1:0] ton,
  input  logic [DT_W-1:0]  dt1,
  input  logic [DT_W-1:0]  dt2,
`ifdef DPWM_OC_TRIP_EN
  input  logic             oc_trip,
  output logic             trip,
`endif
  output logic             c1,
  output logic             c2,
  output logic             clamped,
  output logic             ref_zero
);

  localparam int EW = CNT_W + 1;
  localparam logic [CNT_W-1:0] OFFSET = CNT_W'(phase_offset(PH_IDX, PERIOD, N_PH));
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] pc_r;
  logic [CNT_W-1:0] ton_sh_r;
  logic [DT_W-1:0]  dt1_sh_r;
  logic [DT_W-1:0]  dt2_sh_r;
  logic             armed_r;
  logic             c1_r;
  logic             c2_r;
  logic             clamp_r;

  logic [EW-1:0]    limit_s;
  logic [EW-1:0]    ton_eff_s;
  logic [EW-1:0]    c2_start_s;
  logic [EW-1:0]    pc_ext_s;
  logic             clamp_hit_s;
  logic             wrap_s;
  logic             trip_blk_s;

  // Clamp the latched on-time so the low-side dead-time still fits in the period.
  always_comb begin
    limit_s     = EW'(PERIOD - 1) - EW'(dt2_sh_r);
    clamp_hit_s = ({1'b0, ton_sh_r} > limit_s);
    if (clamp_hit_s) begin
      ton_eff_s = limit_s;
    end else begin
      ton_eff_s = {1'b0, ton_sh_r};
    end
    c2_start_s = ton_eff_s + EW'(dt2_sh_r);
    pc_ext_s   = {1'b0, pc_r};
    wrap_s     = (pc_r == LAST);
  end

`ifdef DPWM_OC_TRIP_EN
  logic trip_r;

  // Trip latches on an over-current event and clears at this phase's next wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      trip_r <= 1'b0;
    end else if (!run) begin
      trip_r <= 1'b0;
    end else if (oc_trip) begin
      trip_r <= 1'b1;
    end else if (wrap_s) begin
      trip_r <= 1'b0;
    end else begin
      trip_r <= trip_r;
    end
  end

  assign trip_blk_s = oc_trip | trip_r;
  assign trip       = trip_r;
`else
  assign trip_blk_s = 1'b0;
`endif

  // Counter, shadow latching and gate registers; shadows only move at a wrap
  // while running so the duty never changes mid-period.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r     <= {CNT_W{1'b0}};
      ton_sh_r <= {CNT_W{1'b0}};
      dt1_sh_r <= {DT_W{1'b0}};
      dt2_sh_r <= {DT_W{1'b0}};
      armed_r  <= 1'b0;
      c1_r     <= 1'b0;
      c2_r     <= 1'b0;
      clamp_r  <= 1'b0;
    end else begin
      clamp_r <= clamp_hit_s;
      if (run) begin
        c1_r <= armed_r && !trip_blk_s && (pc_ext_s >= EW'(dt1_sh_r)) && (pc_ext_s < ton_eff_s);
        c2_r <= armed_r && (pc_ext_s >= c2_start_s);
        if (wrap_s) begin
          pc_r     <= {CNT_W{1'b0}};
          armed_r  <= 1'b1;
          ton_sh_r <= ton;
          dt1_sh_r <= dt1;
          dt2_sh_r <= dt2;
        end else begin
          pc_r <= pc_r + CNT_W'(1);
        end
      end else begin
        c1_r     <= 1'b0;
        c2_r     <= 1'b0;
        ton_sh_r <= ton;
        dt1_sh_r <= dt1;
        dt2_sh_r <= dt2;
        if (start) begin
          pc_r    <= OFFSET;
          armed_r <= (PH_IDX == 0);
        end else begin
          pc_r    <= {CNT_W{1'b0}};
          armed_r <= 1'b0;
        end
      end
    end
  end

  assign c1       = c1_r;
  assign c2       = c2_r;
  assign clamped  = clamp_r;
  assign ref_zero = (PH_IDX == 0) && (pc_r == {CNT_W{1'b0}});

endmodule

// File: rtl/dpwm_multiphase.sv
// Multiphase interleaved DPWM top: IDLE/RUN FSM, period sync pulse and
// OR-reduction of the per-phase status flags.
// Optional feature macro: DPWM_OC_TRIP_EN (over-current trip input/flag).
module dpwm_multiphase
  import smps_pkg::*;
#(
  parameter int CNT_W  = DPWM_CNT_W,
  parameter int DT_W   = DPWM_DT_W,
  parameter int N_PH   = 2,
  parameter int PERIOD = 1000
) (
  input  logic                i_clk,
  input  logic                reset,
  dpwm_multiphase_if.slave    bus
);

  dpwm_state_t     state_r;
  logic            sync_r;
  logic            run_s;
  logic            start_s;
  logic [N_PH-1:0] c1_s;
  logic [N_PH-1:0] c2_s;
  logic [N_PH-1:0] clamp_s;
  logic [N_PH-1:0] zero_s;

  // A drop of i_enable stops the gates on the very next edge.
  assign run_s   = (state_r == RUN)  && bus.i_enable;
  assign start_s = (state_r == IDLE) && bus.i_enable;

  // Run-state FSM and sync pulse aligned with the gate output of count 0.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_r <= IDLE;
      sync_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE:    state_r <= bus.i_enable ? RUN : IDLE;
        RUN:     state_r <= bus.i_enable ? RUN : IDLE;
        default: state_r <= IDLE;
      endcase
      sync_r <= run_s && (|zero_s);
    end
  end

`ifdef DPWM_OC_TRIP_EN
  logic [N_PH-1:0] trip_s;
  assign bus.o_trip = |trip_s;
`endif

  for (genvar k = 0; k < N_PH; k++) begin : g_phase
    dpwm_phase #(
      .CNT_W  (CNT_W),
      .DT_W   (DT_W),
      .PERIOD (PERIOD),
      .N_PH   (N_PH),
      .PH_IDX (k)
    ) u_phase (
      .clk      (i_clk),
      .reset    (reset),
      .run      (run_s),
      .start    (start_s),
      .ton      (bus.i_ton),
      .dt1      (bus.i_dt1),
      .dt2      (bus.i_dt2),
`ifdef DPWM_OC_TRIP_EN
      .oc_trip  (bus.i_oc_trip),
      .trip     (trip_s[k]),
`endif
      .c1       (c1_s[k]),
      .c2       (c2_s[k]),
      .clamped  (clamp_s[k]),
      .ref_zero (zero_s[k])
    );
  end

  assign bus.o_c1      = c1_s;
  assign bus.o_c2      = c2_s;
  assign bus.o_sync    = sync_r;
  assign bus.o_clamped = |clamp_s;
  assign bus.o_running = (state_r == RUN);

endmodule

// File: tb/tb_dpwm_multiphase.sv
// Self-checking bench for dpwm_multiphase (PERIOD=100, N_PH=2).
// Expected gates come from elapsed time since RUN entry: phase position is
// (n + offset) mod PERIOD, and the duty in force is the input set recorded at
// that phase's most recent wrap.
module tb_dpwm_multiphase;

  localparam int P  = 100;
  localparam int NP = 2;
  localparam int CW = 11;
  localparam int DW = 5;

  logic clk = 1'b0;
  logic rst;

  int errors = 0;
  int checks = 0;

  bit active = 1'b0;
  int n = 0;
  int h_ton[P];
  int h_dt1[P];
  int h_dt2[P];

  dpwm_multiphase_if #(.CNT_W(CW), .DT_W(DW), .N_PH(NP)) bus ();

  dpwm_multiphase #(.CNT_W(CW), .DT_W(DW), .N_PH(NP), .PERIOD(P)) dut (
    .i_clk (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock, predict outputs from the time-based model, check at +1.
  task automatic tick();
    logic [NP-1:0] ec1, ec2;
    logic es, er, ecl, do_cl;
    int off, pos, m, idx, t, d1, d2, lim, te;
    bit armed;
    @(posedge clk);
    ec1 = '0; ec2 = '0; es = 1'b0; er = 1'b0; ecl = 1'b0; do_cl = 1'b0;
    if (rst) begin
      active = 1'b0;
    end else if (!active) begin
      if (bus.i_enable) begin
        active = 1'b1;
        n = 0;
        h_ton[0] = int'(bus.i_ton); h_dt1[0] = int'(bus.i_dt1); h_dt2[0] = int'(bus.i_dt2);
        er = 1'b1;
      end
    end else if (!bus.i_enable) begin
      active = 1'b0;
    end else begin
      er = 1'b1;
      do_cl = 1'b1;
      es = ((n % P) == 0);
      for (int k = 0; k < NP; k++) begin
        off = (P - k * (P / NP)) % P;
        pos = (n + off) % P;
        armed = (k == 0) || (n + off >= P);
        m = n - pos;
        if (m < 0) m = 0;
        idx = m % P;
        t = h_ton[idx]; d1 = h_dt1[idx]; d2 = h_dt2[idx];
        lim = P - 1 - d2;
        te = (t > lim) ? lim : t;
        if (t > lim) ecl = 1'b1;
        if (armed) begin
          ec1[k] = (pos >= d1) && (pos < te);
          ec2[k] = (pos >= te + d2);
        end
      end
      n++;
      h_ton[n % P] = int'(bus.i_ton); h_dt1[n % P] = int'(bus.i_dt1); h_dt2[n % P] = int'(bus.i_dt2);
    end
    #1;
    for (int k = 0; k < NP; k++) begin
      chk($sformatf("c1[%0d]", k), 32'(bus.o_c1[k]), 32'(ec1[k]));
      chk($sformatf("c2[%0d]", k), 32'(bus.o_c2[k]), 32'(ec2[k]));
      chk($sformatf("overlap[%0d]", k), 32'(bus.o_c1[k] & bus.o_c2[k]), 32'd0);
    end
    chk("sync", 32'(bus.o_sync), 32'(es));
    chk("running", 32'(bus.o_running), 32'(er));
    if (do_cl) chk("clamped", 32'(bus.o_clamped), 32'(ecl));
  endtask

  initial begin
    rst = 1'b1;
    bus.i_enable = 1'b1;
    bus.i_ton = 11'd40;
    bus.i_dt1 = 5'd2;
    bus.i_dt2 = 5'd2;
`ifdef DPWM_OC_TRIP_EN
    bus.i_oc_trip = 1'b0;
`endif

    // Reset held with enable high: everything stays 0.
    repeat (3) tick();
    chk("reset_running", 32'(bus.o_running), 32'd0);

    // Release: RUN next cycle, ton=40 dt=2 over several periods.
    rst = 1'b0;
    tick();
    chk("release_running", 32'(bus.o_running), 32'd1);
    repeat (150) tick();

    // Change ton at phase-0 count 20; each phase picks it up at its own wrap.
    for (int i = 0; i < 200 && (n % P) != 20; i++) tick();
    bus.i_ton = 11'd60;
    repeat (200) tick();

    // Clamp: ton=200, dt2=3 -> on-time limited to 96.
    bus.i_ton = 11'd200;
    bus.i_dt2 = 5'd3;
    repeat (200) tick();
    chk("clamped_on", 32'(bus.o_clamped), 32'd1);
    bus.i_ton = 11'd50;
    repeat (200) tick();
    chk("clamped_off", 32'(bus.o_clamped), 32'd0);

    // Drop enable at count 30, then re-enable.
    for (int i = 0; i < 200 && (n % P) != 30; i++) tick();
    bus.i_enable = 1'b0;
    tick();
    chk("stop_gates", 32'({bus.o_c1, bus.o_c2}), 32'd0);
    tick();
    bus.i_enable = 1'b1;
    tick();
    tick();
    chk("restart_sync", 32'(bus.o_sync), 32'd1);
    repeat (120) tick();

    // Randomised duty and dead-times with occasional enable drops.
    for (int i = 0; i < 10000; i++) begin
      if ((i % 37) == 0) begin
        bus.i_ton = 11'($urandom_range(0, 120));
        bus.i_dt1 = 5'($urandom_range(0, 31));
        bus.i_dt2 = 5'($urandom_range(0, 31));
      end
      bus.i_enable = ($urandom_range(0, 499) != 0);
      tick();
    end

    // Reset mid-RUN: outputs low on the next edge.
    bus.i_enable = 1'b1;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    chk("midrun_reset", 32'({bus.o_c1, bus.o_c2, bus.o_sync, bus.o_running}), 32'd0);
    rst = 1'b0;
    bus.i_enable = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
